// File: rtl/seg_disp_sched.sv
// seg_disp_sched -- shares the 4-digit 8-segment display driver between
// N_REQ requesters. Round-robin arbitration, minimum display time per
// owner, a blanking gap on each owner change, and the driver scan tick.
//
// Ports:
//   i_CLK        clock, all state changes on the rising edge
//   i_RST_N      synchronous active-low reset
//   i_REQ        request level, one bit per requester
//   i_REQ_DATA   20-bit display words, requester k at [20k+19:20k]
//   o_ACK        one-cycle accept pulse (one-hot or zero)
//   o_DATA       word presented to the driver (16 bits hex + 4 dp)
//   o_OE         driver output enable
//   o_TICK       one-cycle scan strobe, every TICK_DIV cycles
//   o_OWNER      index of the current owner
//   o_BUSY       high when not IDLE
//
// Build option: SEG_DISP_SCHED_AUTOBLANK_EN -- when defined, an owner whose
// hold has expired with no request pending releases the display (back to
// IDLE, OE low, word retained). When undefined, SHOW persists.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner yet (or released), OE low
// SHOW  | owner's word displayed, hold counter running on o_TICK
// BLANK | new word latched, OE low for BLANK_TICKS ticks
module seg_disp_sched #(
   parameter int N_REQ       = 2,
   parameter int TICK_DIV    = 131072,
   parameter int HOLD_TICKS  = 64,
   parameter int BLANK_TICKS = 2
) (
   input  logic                       i_CLK,
   input  logic                       i_RST_N,
   input  logic [N_REQ-1:0]           i_REQ,
   input  logic [20*N_REQ-1:0]        i_REQ_DATA,
   output logic [N_REQ-1:0]           o_ACK,
   output logic [19:0]                o_DATA,
   output logic                       o_OE,
   output logic                       o_TICK,
   output logic [$clog2(N_REQ)-1:0]   o_OWNER,
   output logic                       o_BUSY
);

   localparam int OW = $clog2(N_REQ);
   localparam int PW = $clog2(TICK_DIV);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHOW  = 2'd1;
   localparam logic [1:0] S_BLANK = 2'd2;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [15:0]   HOLD_MAX   = 16'(HOLD_TICKS);
   localparam logic [7:0]    BLANK_LAST = 8'(BLANK_TICKS - 1);

   logic [1:0]    state;
   logic [PW-1:0] presc;
   logic [15:0]   hold_cnt;
   logic [7:0]    blank_cnt;
   logic [OW-1:0] last_owner;
   logic          hold_done;

   logic [19:0]   req_word [N_REQ];
   logic [OW:0]   rr_k;
   logic [OW-1:0] win_idx;
   logic [OW-1:0] oth_idx;
   logic          any_win;
   logic          any_oth;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_word[i] = i_REQ_DATA[20*i +: 20];
      end
   end

   // Search from last_owner+1 with wrap. Walking the offsets downward lets
   // the nearest hit overwrite the farther ones. Offset N_REQ is last_owner
   // itself: eligible from IDLE, excluded for a hand-over ("other").
   always_comb begin
      rr_k    = '0;
      win_idx = last_owner;
      oth_idx = last_owner;
      any_win = 1'b0;
      any_oth = 1'b0;
      for (int i = N_REQ; i >= 1; i--) begin
         rr_k = {1'b0, last_owner} + (OW+1)'(i);
         if (rr_k >= (OW+1)'(N_REQ)) begin
            rr_k = rr_k - (OW+1)'(N_REQ);
         end
         if (i_REQ[rr_k[OW-1:0]]) begin
            win_idx = rr_k[OW-1:0];
            any_win = 1'b1;
            if (i != N_REQ) begin
               oth_idx = rr_k[OW-1:0];
               any_oth = 1'b1;
            end
         end
      end
   end

   assign hold_done = (hold_cnt >= HOLD_MAX);

   always_ff @(posedge i_CLK) begin
      if (!i_RST_N) begin
         state      <= S_IDLE;
         presc      <= '0;
         hold_cnt   <= '0;
         blank_cnt  <= '0;
         last_owner <= OW'(N_REQ - 1);
         o_ACK      <= '0;
         o_DATA     <= '0;
         o_OE       <= 1'b0;
         o_TICK     <= 1'b0;
         o_OWNER    <= '0;
         o_BUSY     <= 1'b0;
      end else begin
         o_ACK <= '0;

         if (presc == PRESC_LAST) begin
            presc  <= '0;
            o_TICK <= 1'b1;
         end else begin
            presc  <= presc + 1'b1;
            o_TICK <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (any_win) begin
                  o_ACK      <= N_REQ'(1) << win_idx;
                  o_DATA     <= req_word[win_idx];
                  o_OWNER    <= win_idx;
                  last_owner <= win_idx;
                  hold_cnt   <= '0;
                  o_OE       <= 1'b1;
                  o_BUSY     <= 1'b1;
                  state      <= S_SHOW;
               end
            end

            S_SHOW: begin
               // saturate so the counter cannot wrap on a long hold
               if (o_TICK && !hold_done) begin
                  hold_cnt <= hold_cnt + 16'd1;
               end
               if (hold_done && any_oth) begin
                  o_ACK      <= N_REQ'(1) << oth_idx;
                  o_DATA     <= req_word[oth_idx];
                  o_OWNER    <= oth_idx;
                  last_owner <= oth_idx;
                  blank_cnt  <= '0;
                  o_OE       <= 1'b0;
                  state      <= S_BLANK;
               end else if (i_REQ[o_OWNER]) begin
                  // owner refresh: new word, hold keeps running
                  o_ACK  <= N_REQ'(1) << o_OWNER;
                  o_DATA <= req_word[o_OWNER];
`ifdef SEG_DISP_SCHED_AUTOBLANK_EN
               end else if (hold_done) begin
                  o_OE   <= 1'b0;
                  o_BUSY <= 1'b0;
                  state  <= S_IDLE;
`endif
               end
            end

            S_BLANK: begin
               if (o_TICK) begin
                  if (blank_cnt == BLANK_LAST) begin
                     hold_cnt <= '0;
                     o_OE     <= 1'b1;
                     state    <= S_SHOW;
                  end else begin
                     blank_cnt <= blank_cnt + 8'd1;
                  end
               end
            end

            default: begin
               o_OE   <= 1'b0;
               o_BUSY <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed bench for seg_disp_sched with N_REQ=2, TICK_DIV=4,
// HOLD_TICKS=2, BLANK_TICKS=1. Edge counts after each reset release are
// tracked in cyc; the scan tick is expected after every 4th edge.
module tb_seg_disp_sched;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [39:0] req_data;
   logic [1:0]  ack;
   logic [19:0] data;
   logic        oe;
   logic        tick;
   logic        owner;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit tick_en = 0;

   seg_disp_sched #(
      .N_REQ(2), .TICK_DIV(4), .HOLD_TICKS(2), .BLANK_TICKS(1)
   ) dut (
      .i_CLK(clk), .i_RST_N(rst_n), .i_REQ(req), .i_REQ_DATA(req_data),
      .o_ACK(ack), .o_DATA(data), .o_OE(oe), .o_TICK(tick),
      .o_OWNER(owner), .o_BUSY(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one rising edge, sample 1 time unit later; tick checked while enabled
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (tick_en) chk("tick", 32'(tick), (cyc % 4 == 0) ? 1 : 0);
   endtask

   task automatic stepn(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ack"},   32'(ack),   0);
      chk({tag, "_data"},  32'(data),  0);
      chk({tag, "_oe"},    32'(oe),    0);
      chk({tag, "_tick"},  32'(tick),  0);
      chk({tag, "_owner"}, 32'(owner), 0);
      chk({tag, "_busy"},  32'(busy),  0);
   endtask

   initial begin
      rst_n    = 1'b0;
      req      = 2'b01;
      req_data = {20'h00000, 20'h12345};

      // 1: reset with a pending request
      for (int i = 0; i < 3; i++) begin
         step();
         chk_zero("rst");
      end
      rst_n = 1'b1; cyc = 0; tick_en = 1;
      step();                                   // E1
      chk("first_ack",   32'(ack),   'h1);
      chk("first_data",  32'(data),  'h12345);
      chk("first_oe",    32'(oe),    1);
      chk("first_owner", 32'(owner), 0);
      chk("first_busy",  32'(busy),  1);
      req = 2'b00;

      // 2: prescaler (tick checked inside step), 3: owner update
      stepn(4);                                 // E2..E5
      req = 2'b01; req_data[19:0] = 20'hABCDE;
      step();                                   // E6
      chk("upd_ack",  32'(ack),  'h1);
      chk("upd_data", 32'(data), 'hABCDE);
      chk("upd_oe",   32'(oe),   1);
      req = 2'b00;
      step();                                   // E7
      chk("upd_ack_clr", 32'(ack), 0);
      chk("upd_oe_hold", 32'(oe),  1);

      // 4: contention, hold expires after the 2nd tick
      req = 2'b10; req_data[39:20] = 20'h0F00F;
      step();                                   // E8
      chk("cont_noack8", 32'(ack), 0);
      step();                                   // E9
      chk("cont_noack9", 32'(ack), 0);
      step();                                   // E10
      chk("cont_ack",   32'(ack),   'h2);
      chk("cont_data",  32'(data),  'h0F00F);
      chk("cont_owner", 32'(owner), 1);
      chk("cont_oe",    32'(oe),    0);
      req = 2'b00;
      step();                                   // E11
      chk("blank_oe11", 32'(oe), 0);
      step();                                   // E12
      chk("blank_oe12", 32'(oe), 0);
      step();                                   // E13
      chk("show_oe",    32'(oe),    1);
      chk("show_owner", 32'(owner), 1);
      chk("show_busy",  32'(busy),  1);

      // reset mid-SHOW, then 5: simultaneous requests and fairness
      rst_n = 1'b0; tick_en = 0;
      req = 2'b11; req_data = {20'h22222, 20'h11111};
      step();
      chk_zero("rst_mid");
      rst_n = 1'b1; cyc = 0; tick_en = 1;
      step();                                   // F1
      chk("sim_ack",   32'(ack),   'h1);
      chk("sim_data",  32'(data),  'h11111);
      chk("sim_owner", 32'(owner), 0);
      step();                                   // F2: req0 still high -> new request
      chk("sim_reack", 32'(ack), 'h1);
      stepn(7);                                 // F9
      chk("sim_reack9", 32'(ack), 'h1);
      step();                                   // F10
      chk("fair1_ack",   32'(ack),   'h2);
      chk("fair1_data",  32'(data),  'h22222);
      chk("fair1_owner", 32'(owner), 1);
      chk("fair1_oe",    32'(oe),    0);
      req = 2'b01;
      step();                                   // F11
      chk("blank_noack11", 32'(ack), 0);
      step();                                   // F12
      chk("blank_noack12", 32'(ack), 0);
      chk("blank_oe_f12",  32'(oe),  0);
      step();                                   // F13
      chk("fair1_show_oe", 32'(oe),  1);
      chk("fair1_noack",   32'(ack), 0);
      stepn(8);                                 // F21
      chk("fair_wait_ack", 32'(ack),   0);
      chk("fair_wait_own", 32'(owner), 1);
      step();                                   // F22
      chk("fair2_ack",   32'(ack),   'h1);
      chk("fair2_data",  32'(data),  'h11111);
      chk("fair2_owner", 32'(owner), 0);
      chk("fair2_oe",    32'(oe),    0);
      req = 2'b00;
      stepn(2);                                 // F24
      chk("fair2_blank_oe", 32'(oe), 0);
      step();                                   // F25
      chk("fair2_show_oe", 32'(oe), 1);

      // 6: hold expires with no requests
      stepn(8);                                 // F33
      chk("pre_exp_oe", 32'(oe), 1);
      step();                                   // F34
`ifdef SEG_DISP_SCHED_AUTOBLANK_EN
      chk("ab_oe",   32'(oe),   0);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_data", 32'(data), 'h11111);
      req = 2'b10; req_data[39:20] = 20'h33333;
      step();
      chk("ab_ack",   32'(ack),   'h2);
      chk("ab_data2", 32'(data),  'h33333);
      chk("ab_owner", 32'(owner), 1);
      chk("ab_oe2",   32'(oe),    1);
      chk("ab_busy2", 32'(busy),  1);
`else
      chk("persist_oe0",   32'(oe),   1);
      chk("persist_busy0", 32'(busy), 1);
      for (int i = 0; i < 400; i++) begin
         step();
         chk("persist_oe", 32'(oe), 1);
      end
      chk("persist_data", 32'(data), 'h11111);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_disp_sched.md
# seg_disp_sched

Display scheduler that shares the 4-digit 8-segment display driver between several requesters, such as a CPU port, the LFSR pattern source and debug status. Requesters hand over a 20-bit display word (16 bits of hex nibbles plus 4 decimal points) through a req/ack handshake. The block arbitrates round-robin and enforces a minimum display time per owner. It inserts a blanking gap on every owner change and generates the scan tick that clocks the driver. Its outputs feed the driver's data, output-enable and scan-clock inputs directly.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `TICK_DIV`, default 131072: i_CLK cycles per scan tick, minimum 2.
- `HOLD_TICKS`, default 64: minimum ticks an owner keeps the display, 1..65535.
- `BLANK_TICKS`, default 2: ticks with OE low on an owner change, 1..255.
- `i_CLK`, input, 1: the single clock; all state changes on its rising edge.
- `i_RST_N`, input, 1: reset, synchronous and active-low.
- `i_REQ`, input, N_REQ: request level, one bit per requester.
- `i_REQ_DATA`, input, 20*N_REQ: display words; requester k occupies bits [20k+19:20k].
- `o_ACK`, output, N_REQ: one-cycle accept pulse, one-hot or zero.
- `o_DATA`, output, 20: word presented to the display driver.
- `o_OE`, output, 1: driver output enable.
- `o_TICK`, output, 1: one-cycle scan strobe that advances the driver's digit.
- `o_OWNER`, output, `$clog2(N_REQ)`: index of the current owner.
- `o_BUSY`, output, 1: high when the state is not IDLE.

## Operation
- **Prescaler:** free-running, 0..TICK_DIV-1. `o_TICK` is registered and goes high for one cycle when the count wraps.
- **States:** IDLE, SHOW, BLANK.
- **IDLE:**
  - `o_OE` = 0.
  - When any `i_REQ` is high: the winner gets `o_ACK`, its data is captured into `o_DATA`, `o_OWNER` takes its index, and the state goes to SHOW. No blanking is needed.
- **SHOW:**
  - `o_OE` = 1. The hold counter clears on entry and increments on each `o_TICK`. The hold is expired when the count is at least HOLD_TICKS.
  - **Owner request:** accepted at any time with ack and a data capture. This does not restart the hold counter.
  - **Hold expired, another requester pending:** round-robin winner is chosen; it gets ack and its data is captured. The state goes to BLANK. A simultaneous owner request is not acked.
  - **Hold expired, no other requester pending:** stay in SHOW.
- **BLANK:**
  - `o_OE` = 0 and `o_DATA` already holds the new word. The blank counter increments on each tick.
  - On the tick that brings the count to BLANK_TICKS, the state goes to SHOW.
  - Requests are not acked during BLANK, including the new owner's.
- **Round-robin:** the search starts at index `last_owner+1` and wraps. After reset `last_owner` = N_REQ-1, so requester 0 wins first.
- **Handshake:**
  - A requester holds req and data stable until it sees ack, then drops req on the following cycle.
  - If req is still high on the cycle after ack, it is a new request.
- **Reset**, including mid-SHOW or mid-BLANK:
  - State IDLE, prescaler 0, counters 0, `last_owner` = N_REQ-1.
  - `o_DATA` = 0, `o_OE` = 0, `o_ACK` = 0, `o_TICK` = 0, `o_OWNER` = 0, `o_BUSY` = 0.

## Timing
- All outputs are registered.
- `o_ACK` and the new `o_DATA`/`o_OWNER` appear on the edge after the cycle in which req is sampled high, giving one-cycle latency.
- `o_OE` changes on that same edge for IDLE→SHOW and SHOW→BLANK. It rises on the edge after the last blank tick.
- First `o_TICK` occurs TICK_DIV cycles after reset is released.
- The owner keeps the display for at least HOLD_TICKS ticks. The owner-to-owner gap is exactly BLANK_TICKS ticks with OE low.

## Configuration
- Macro: `SEG_DISP_SCHED_AUTOBLANK_EN`.
- **Defined:** in SHOW, if the hold has expired and no `i_REQ` bit is high, the block goes to IDLE. `o_OE` drops on the next edge and `o_DATA` is retained. The next request goes IDLE→SHOW with no blanking.
- **Undefined:** SHOW persists indefinitely and the display keeps its last word.

## Test plan
All scenarios use N_REQ=2, TICK_DIV=4, HOLD_TICKS=2, BLANK_TICKS=1 unless stated.

1. **Reset with pending request.** `i_RST_N` low for 3 cycles with req0=1 and data0=0x12345 → all outputs 0 and no ack during reset. First edge after release → `o_ACK`=01, `o_DATA`=0x12345, `o_OE`=1, `o_OWNER`=0.
2. **Prescaler.** Release reset → `o_TICK` pulses exactly every 4 cycles, first at cycle 4, each pulse 1 cycle wide.
3. **Owner update.** In SHOW as owner 0, pulse req0 with 0xABCDE before the hold expires → `o_ACK`=01 the next cycle, `o_DATA`=0xABCDE, `o_OE` stays 1, no BLANK.
4. **Contention.** Owner 0 in SHOW; req1 is held with 0x0F00F from entry → no ack until the 2nd tick. Then `o_ACK`=10, `o_DATA`=0x0F00F, `o_OE`=0 for 1 tick, then `o_OE`=1 with `o_OWNER`=1.
5. **Simultaneous and fairness.** req0 and req1 both high from IDLE → requester 0 acked first. After the hold, requester 1 is acked while req0 is still high. After the next hold, requester 0 is granted again.
6. **Autoblank.** All req low after the hold expires. With `SEG_DISP_SCHED_AUTOBLANK_EN` → `o_OE`=0 and `o_BUSY`=0 one cycle after expiry. Without the macro → `o_OE` stays 1 for at least 100 ticks.
